// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Types, sizes and helpers shared by the NPU memory-loading logic.
//   target_e      : destination RAM selector for a load command
//   state_e       : loader FSM states
//   IMAGE_*       : image RAM is 4 byte-wide banks of 1024 words
//   PARAM_*       : conv/dense/denseb RAMs are 32768 bytes each
//   cmd_is_legal  : range check for a load command
// ---------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [1:0] {
        TGT_IMAGE  = 2'd0,
        TGT_CONV   = 2'd1,
        TGT_DENSE  = 2'd2,
        TGT_DENSEB = 2'd3
    } target_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam int IMAGE_WORDS = 1024;
    localparam int IMAGE_BANKS = 4;
    localparam int PARAM_DEPTH = 32768;
    localparam int IMAGE_AW    = 10;
    localparam int PARAM_AW    = 15;

    // A command is legal when it moves at least one byte and its last byte
    // still lands inside the selected RAM. The image RAM is addressed in
    // 4-byte words, so its start address is scaled to bytes first. The sum
    // is carried in 17 bits so it cannot overflow before the compare.
    function automatic logic cmd_is_legal(input target_e              target,
                                          input logic [PARAM_AW-1:0]  base,
                                          input logic [15:0]          len);
        logic [16:0] end_excl;
        logic [16:0] limit;
        if (target == TGT_IMAGE) begin
            end_excl = {5'd0, base[IMAGE_AW-1:0], 2'b00} + {1'b0, len};
            limit    = 17'(IMAGE_WORDS * IMAGE_BANKS);
        end else begin
            end_excl = {2'd0, base} + {1'b0, len};
            limit    = 17'(PARAM_DEPTH);
        end
        return (len != 16'd0) && (end_excl <= limit);
    endfunction

endpackage

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Streams bytes from a valid/ready input into one of the NPU RAMs.
//   clk, reset           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : load command handshake (ready only while idle)
//   cmd_target/base/len  : destination RAM, start address, byte count
//   in_valid/in_ready    : byte stream handshake (ready only while loading)
//   in_data              : byte payload
//   abort                : cancels the load in progress
//   image_ram_addr_a, data_image0..3, we_image0..3 : image RAM write ports
//   conv/dense/denseb_ram_addr_a, data_*, we_*     : parameter RAM ports
//   busy                 : a load is in progress
//   done                 : pulses with the final write strobe
//   err                  : pulses the cycle after a rejected command
// All write ports are registered: a byte accepted in cycle N is written in
// cycle N+1 with address, data and strobe valid together.
// ---------------------------------------------------------------------------
module mem_loader
    import npu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_target,
    input  logic [PARAM_AW-1:0] cmd_base,
    input  logic [15:0]         cmd_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                abort,
    output logic [IMAGE_AW-1:0] image_ram_addr_a,
    output logic [7:0]          data_image0,
    output logic [7:0]          data_image1,
    output logic [7:0]          data_image2,
    output logic [7:0]          data_image3,
    output logic                we_image0,
    output logic                we_image1,
    output logic                we_image2,
    output logic                we_image3,
    output logic [PARAM_AW-1:0] conv_ram_addr_a,
    output logic [PARAM_AW-1:0] dense_ram_addr_a,
    output logic [PARAM_AW-1:0] denseb_ram_addr_a,
    output logic [7:0]          data_conv,
    output logic [7:0]          data_dense,
    output logic [7:0]          data_denseb,
    output logic                we_conv,
    output logic                we_dense,
    output logic                we_denseb,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e                state_q;
    target_e               tgt_q;
    logic [PARAM_AW-1:0]   addr_q;
    logic [1:0]            bank_q;
    logic [15:0]           remain_q;

    logic [IMAGE_AW-1:0]   img_addr_q;
    logic [3:0][7:0]       img_data_q;
    logic [3:0]            img_we_q;
    logic [PARAM_AW-1:0]   conv_addr_q;
    logic [PARAM_AW-1:0]   dense_addr_q;
    logic [PARAM_AW-1:0]   denseb_addr_q;
    logic [7:0]            conv_data_q;
    logic [7:0]            dense_data_q;
    logic [7:0]            denseb_data_q;
    logic                  conv_we_q;
    logic                  dense_we_q;
    logic                  denseb_we_q;
    logic                  done_q;
    logic                  err_q;

    target_e               cmd_tgt;
    logic                  cmd_legal;
    logic [PARAM_AW-1:0]   addr_d;
    logic [1:0]            bank_d;
    logic [15:0]           remain_d;

    assign cmd_tgt   = target_e'(cmd_target);
    assign cmd_legal = cmd_is_legal(cmd_tgt, cmd_base, cmd_len);

    // The image RAM advances one word every four bytes (one per bank);
    // the parameter RAMs advance one byte address per byte.
    assign bank_d   = bank_q + 2'd1;
    assign addr_d   = (tgt_q != TGT_IMAGE || bank_q == 2'd3) ? addr_q + 1'b1 : addr_q;
    assign remain_d = remain_q - 16'd1;

    // Loader FSM together with all registered write-port outputs. Strobes,
    // done and err default low every cycle so each is a single-cycle pulse.
    // Counters only advance when another byte is still due, so they never
    // step past the end of the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tgt_q         <= TGT_IMAGE;
            addr_q        <= '0;
            bank_q        <= '0;
            remain_q      <= '0;
            img_addr_q    <= '0;
            img_data_q    <= '0;
            img_we_q      <= '0;
            conv_addr_q   <= '0;
            dense_addr_q  <= '0;
            denseb_addr_q <= '0;
            conv_data_q   <= '0;
            dense_data_q  <= '0;
            denseb_data_q <= '0;
            conv_we_q     <= 1'b0;
            dense_we_q    <= 1'b0;
            denseb_we_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            img_we_q    <= '0;
            conv_we_q   <= 1'b0;
            dense_we_q  <= 1'b0;
            denseb_we_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A command arriving with abort is swallowed without err.
                    if (cmd_valid && !abort) begin
                        if (cmd_legal) begin
                            state_q  <= ST_LOAD;
                            tgt_q    <= cmd_tgt;
                            addr_q   <= (cmd_tgt == TGT_IMAGE) ?
                                        {5'd0, cmd_base[IMAGE_AW-1:0]} : cmd_base;
                            bank_q   <= 2'd0;
                            remain_q <= cmd_len;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // A byte accepted alongside abort is dropped.
                    if (abort) begin
                        state_q  <= ST_IDLE;
                        remain_q <= '0;
                    end else if (in_valid) begin
                        case (tgt_q)
                            TGT_IMAGE: begin
                                img_we_q[bank_q]   <= 1'b1;
                                img_addr_q         <= addr_q[IMAGE_AW-1:0];
                                img_data_q[bank_q] <= in_data;
                            end
                            TGT_CONV: begin
                                conv_we_q   <= 1'b1;
                                conv_addr_q <= addr_q;
                                conv_data_q <= in_data;
                            end
                            TGT_DENSE: begin
                                dense_we_q   <= 1'b1;
                                dense_addr_q <= addr_q;
                                dense_data_q <= in_data;
                            end
                            TGT_DENSEB: begin
                                denseb_we_q   <= 1'b1;
                                denseb_addr_q <= addr_q;
                                denseb_data_q <= in_data;
                            end
                        endcase
                        if (remain_q == 16'd1) begin
                            state_q  <= ST_IDLE;
                            done_q   <= 1'b1;
                            remain_q <= '0;
                        end else begin
                            remain_q <= remain_d;
                            addr_q   <= addr_d;
                            bank_q   <= bank_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready         = (state_q == ST_IDLE);
    assign in_ready          = (state_q == ST_LOAD);
    assign busy              = (state_q == ST_LOAD);
    assign done              = done_q;
    assign err               = err_q;
    assign image_ram_addr_a  = img_addr_q;
    assign data_image0       = img_data_q[0];
    assign data_image1       = img_data_q[1];
    assign data_image2       = img_data_q[2];
    assign data_image3       = img_data_q[3];
    assign we_image0         = img_we_q[0];
    assign we_image1         = img_we_q[1];
    assign we_image2         = img_we_q[2];
    assign we_image3         = img_we_q[3];
    assign conv_ram_addr_a   = conv_addr_q;
    assign dense_ram_addr_a  = dense_addr_q;
    assign denseb_ram_addr_a = denseb_addr_q;
    assign data_conv         = conv_data_q;
    assign data_dense        = dense_data_q;
    assign data_denseb       = denseb_data_q;
    assign we_conv           = conv_we_q;
    assign we_dense          = dense_we_q;
    assign we_denseb         = denseb_we_q;

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
// Drives directed load sequences into mem_loader. A transaction-level model
// predicts handshakes, strobes, addresses and data each cycle; writes seen
// on the RAM ports are also collected into a byte map that directed checks
// compare with hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_target;
    logic [14:0] cmd_base;
    logic [15:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        abort;
    logic [9:0]  image_ram_addr_a;
    logic [7:0]  data_image0, data_image1, data_image2, data_image3;
    logic        we_image0, we_image1, we_image2, we_image3;
    logic [14:0] conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a;
    logic [7:0]  data_conv, data_dense, data_denseb;
    logic        we_conv, we_dense, we_denseb;
    logic        busy, done, err;

    mem_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
        .image_ram_addr_a(image_ram_addr_a),
        .data_image0(data_image0), .data_image1(data_image1),
        .data_image2(data_image2), .data_image3(data_image3),
        .we_image0(we_image0), .we_image1(we_image1),
        .we_image2(we_image2), .we_image3(we_image3),
        .conv_ram_addr_a(conv_ram_addr_a), .dense_ram_addr_a(dense_ram_addr_a),
        .denseb_ram_addr_a(denseb_ram_addr_a),
        .data_conv(data_conv), .data_dense(data_dense), .data_denseb(data_denseb),
        .we_conv(we_conv), .we_dense(we_dense), .we_denseb(we_denseb),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed writes: image key = bank*1024+word, parameter key = tgt*65536+addr
    logic [7:0] obsMem [int];
    int         writeCount = 0;
    int         doneCount  = 0;
    int         errCount   = 0;
    int         cycle      = 0;
    int         doneCycle  = -1;
    int         writeCycles[$];

    // Model state: which load is active and how many bytes it has taken
    bit         mActive = 1'b0;
    int         mTgt, mBase, mLen, mK;
    logic [3:0] eWeImg = '0;
    logic       eWeConv = 1'b0, eWeDense = 1'b0, eWeDenseb = 1'b0;
    logic       eDone = 1'b0, eErr = 1'b0, eRst = 1'b0;
    int         eAddr = 0;
    logic [7:0] eData = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int obsParam(input int tgt, input int addr);
        int k = tgt * 65536 + addr;
        return obsMem.exists(k) ? int'(obsMem[k]) : -1;
    endfunction

    function automatic int obsImage(input int bank, input int word);
        int k = bank * 1024 + word;
        return obsMem.exists(k) ? int'(obsMem[k]) : -1;
    endfunction

    function automatic logic [7:0] imgData(input int b);
        case (b)
            0: return data_image0;
            1: return data_image1;
            2: return data_image2;
            default: return data_image3;
        endcase
    endfunction

    // Transaction model: byte k of a load goes to base+k, or for the image
    // RAM to bank k%4 at word base+k/4, one cycle after it is accepted.
    always @(posedge clk) begin
        int start, limit;
        eWeImg = '0; eWeConv = 1'b0; eWeDense = 1'b0; eWeDenseb = 1'b0;
        eDone = 1'b0; eErr = 1'b0; eRst = reset;
        if (reset) begin
            mActive = 1'b0;
        end else if (!mActive) begin
            if (cmd_valid && !abort) begin
                if (cmd_target == 2'd0) begin
                    start = int'(cmd_base[9:0]) * 4;
                    limit = 4096;
                end else begin
                    start = int'(cmd_base);
                    limit = 32768;
                end
                if (cmd_len != 16'd0 && start + int'(cmd_len) <= limit) begin
                    mActive = 1'b1;
                    mTgt    = int'(cmd_target);
                    mBase   = (mTgt == 0) ? int'(cmd_base[9:0]) : int'(cmd_base);
                    mLen    = int'(cmd_len);
                    mK      = 0;
                end else begin
                    eErr = 1'b1;
                end
            end
        end else if (abort) begin
            mActive = 1'b0;
        end else if (in_valid) begin
            eData = in_data;
            case (mTgt)
                0: begin eWeImg[2'(mK % 4)] = 1'b1; eAddr = mBase + mK / 4; end
                1: begin eWeConv = 1'b1;   eAddr = mBase + mK; end
                2: begin eWeDense = 1'b1;  eAddr = mBase + mK; end
                default: begin eWeDenseb = 1'b1; eAddr = mBase + mK; end
            endcase
            mK++;
            if (mK == mLen) begin
                mActive = 1'b0;
                eDone   = 1'b1;
            end
        end
    end

    // Compare DUT against the model every cycle, then log what was written.
    always @(posedge clk) begin
        #1;
        cycle++;
        checkOutput("cmd_ready", cmd_ready, !mActive);
        checkOutput("in_ready", in_ready, mActive);
        checkOutput("busy", busy, mActive);
        checkOutput("we_image", {we_image3, we_image2, we_image1, we_image0}, eWeImg);
        checkOutput("we_conv", we_conv, eWeConv);
        checkOutput("we_dense", we_dense, eWeDense);
        checkOutput("we_denseb", we_denseb, eWeDenseb);
        checkOutput("done", done, eDone);
        checkOutput("err", err, eErr);
        for (int b = 0; b < 4; b++) begin
            if (eWeImg[b]) begin
                checkOutput("image_addr", image_ram_addr_a, eAddr);
                checkOutput("image_data", imgData(b), eData);
            end
        end
        if (eWeConv) begin
            checkOutput("conv_addr", conv_ram_addr_a, eAddr);
            checkOutput("conv_data", data_conv, eData);
        end
        if (eWeDense) begin
            checkOutput("dense_addr", dense_ram_addr_a, eAddr);
            checkOutput("dense_data", data_dense, eData);
        end
        if (eWeDenseb) begin
            checkOutput("denseb_addr", denseb_ram_addr_a, eAddr);
            checkOutput("denseb_data", data_denseb, eData);
        end
        if (eRst) begin
            checkOutput("rst_image_addr", image_ram_addr_a, 0);
            checkOutput("rst_image_data", {data_image3, data_image2, data_image1, data_image0}, 0);
            checkOutput("rst_param_addr", {2'b0, conv_ram_addr_a} | {2'b0, dense_ram_addr_a}
                                          | {2'b0, denseb_ram_addr_a}, 0);
            checkOutput("rst_param_data", {data_conv, data_dense, data_denseb}, 0);
        end
        if (we_image0) obsMem[0 * 1024 + int'(image_ram_addr_a)] = data_image0;
        if (we_image1) obsMem[1 * 1024 + int'(image_ram_addr_a)] = data_image1;
        if (we_image2) obsMem[2 * 1024 + int'(image_ram_addr_a)] = data_image2;
        if (we_image3) obsMem[3 * 1024 + int'(image_ram_addr_a)] = data_image3;
        if (we_conv)   obsMem[1 * 65536 + int'(conv_ram_addr_a)]   = data_conv;
        if (we_dense)  obsMem[2 * 65536 + int'(dense_ram_addr_a)]  = data_dense;
        if (we_denseb) obsMem[3 * 65536 + int'(denseb_ram_addr_a)] = data_denseb;
        if (we_image0 | we_image1 | we_image2 | we_image3 | we_conv | we_dense | we_denseb) begin
            writeCount += int'(we_image0) + int'(we_image1) + int'(we_image2) + int'(we_image3)
                        + int'(we_conv) + int'(we_dense) + int'(we_denseb);
            writeCycles.push_back(cycle);
        end
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
        if (err) errCount++;
    end

    task automatic applyStimulus(input logic cv, input logic [1:0] tgt, input logic [14:0] base,
                                 input logic [15:0] len, input logic iv, input logic [7:0] d,
                                 input logic ab);
        @(negedge clk);
        cmd_valid  = cv;
        cmd_target = tgt;
        cmd_base   = base;
        cmd_len    = len;
        in_valid   = iv;
        in_data    = d;
        abort      = ab;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 2'd0, 15'd0, 16'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic sendCmd(input logic [1:0] tgt, input logic [14:0] base, input logic [15:0] len);
        applyStimulus(1'b1, tgt, base, len, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic ab);
        applyStimulus(1'b0, 2'd0, 15'd0, 16'd0, 1'b1, d, ab);
    endtask

    // Image word/bank keys for base=5, bytes 1..6, in byte order
    int imgKeys[6] = '{5, 1029, 2053, 3077, 6, 1030};

    initial begin
        int w0, d0, e0, nq;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_target = '0; cmd_base = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_we", {we_image3, we_image2, we_image1, we_image0,
                                 we_conv, we_dense, we_denseb}, 0);
        checkOutput("reset_flags", {busy, done, err, in_ready}, 0);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        idleCycles(1);

        // conv base=100, three back-to-back bytes
        w0 = writeCount; d0 = doneCount; nq = writeCycles.size();
        sendCmd(2'd1, 15'd100, 16'd3);
        sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0); sendByte(8'h33, 1'b0);
        idleCycles(3);
        checkOutput("conv100", obsParam(1, 100), 32'h11);
        checkOutput("conv101", obsParam(1, 101), 32'h22);
        checkOutput("conv102", obsParam(1, 102), 32'h33);
        checkOutput("conv_writes", writeCount - w0, 3);
        checkOutput("conv_done", doneCount - d0, 1);
        if (writeCycles.size() >= nq + 3) begin
            checkOutput("conv_consecutive", writeCycles[nq + 2] - writeCycles[nq], 2);
            checkOutput("conv_done_with_last", doneCycle, writeCycles[nq + 2]);
        end else begin
            checkOutput("conv_write_cycles", writeCycles.size() - nq, 3);
        end

        // image base=5, bytes 1..6 spread over banks
        sendCmd(2'd0, 15'd5, 16'd6);
        for (int i = 1; i <= 6; i++) sendByte(8'(i), 1'b0);
        idleCycles(2);
        for (int i = 0; i < 6; i++)
            checkOutput("image_byte", obsMem.exists(imgKeys[i]) ? int'(obsMem[imgKeys[i]]) : -1, i + 1);
        checkOutput("image_w6b2_unwritten", obsImage(2, 6), -1);

        // dense base=32760 len=9 runs past the end: rejected
        w0 = writeCount; e0 = errCount;
        sendCmd(2'd2, 15'd32760, 16'd9);
        idleCycles(1);
        checkOutput("reject_err_pulse", err, 1);
        checkOutput("reject_cmd_ready", cmd_ready, 1);
        sendByte(8'h5A, 1'b0);
        idleCycles(2);
        checkOutput("reject_no_writes", writeCount - w0, 0);
        checkOutput("reject_err_count", errCount - e0, 1);

        // boundaries: last parameter byte, image overrun, zero length
        d0 = doneCount; e0 = errCount;
        sendCmd(2'd2, 15'd32764, 16'd4);
        for (int i = 0; i < 4; i++) sendByte(8'(8'hC0 + i), 1'b0);
        idleCycles(2);
        checkOutput("dense32767", obsParam(2, 32767), 32'hC3);
        checkOutput("dense_edge_done", doneCount - d0, 1);
        sendCmd(2'd0, 15'd1023, 16'd5);
        idleCycles(1);
        sendCmd(2'd3, 15'd10, 16'd0);
        idleCycles(2);
        checkOutput("edge_rejects", errCount - e0, 2);

        // abort alongside a command: swallowed, no err, no load
        w0 = writeCount; e0 = errCount;
        applyStimulus(1'b1, 2'd1, 15'd700, 16'd2, 1'b0, 8'd0, 1'b1);
        sendByte(8'h77, 1'b0);
        idleCycles(2);
        checkOutput("abort_cmd_err", errCount - e0, 0);
        checkOutput("abort_cmd_writes", writeCount - w0, 0);

        // denseb len=4, abort with byte 3
        w0 = writeCount; d0 = doneCount;
        sendCmd(2'd3, 15'd200, 16'd4);
        sendByte(8'd1, 1'b0); sendByte(8'd2, 1'b0); sendByte(8'd3, 1'b1);
        idleCycles(1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cmd_ready", cmd_ready, 1);
        idleCycles(2);
        checkOutput("denseb200", obsParam(3, 200), 1);
        checkOutput("denseb201", obsParam(3, 201), 2);
        checkOutput("denseb202", obsParam(3, 202), -1);
        checkOutput("abort_writes", writeCount - w0, 2);
        checkOutput("abort_no_done", doneCount - d0, 0);

        // reset during a conv load of 10 after 4 bytes
        w0 = writeCount;
        sendCmd(2'd1, 15'd300, 16'd10);
        for (int i = 0; i < 4; i++) sendByte(8'(8'hA0 + i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("midreset_we", {we_image3, we_image2, we_image1, we_image0,
                                    we_conv, we_dense, we_denseb}, 0);
        checkOutput("midreset_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sendCmd(2'd1, 15'd500, 16'd1);
        sendByte(8'hAB, 1'b0);
        idleCycles(2);
        checkOutput("conv303", obsParam(1, 303), 32'hA3);
        checkOutput("conv304", obsParam(1, 304), -1);
        checkOutput("conv500", obsParam(1, 500), 32'hAB);
        checkOutput("reset_writes", writeCount - w0, 5);

        // conv len=4 with in_valid toggling every cycle
        w0 = writeCount; d0 = doneCount; nq = writeCycles.size();
        sendCmd(2'd1, 15'd600, 16'd4);
        for (int i = 0; i < 4; i++) begin
            sendByte(8'(8'h51 + i), 1'b0);
            idleCycles(1);
        end
        idleCycles(2);
        checkOutput("gap_writes", writeCount - w0, 4);
        checkOutput("gap_done", doneCount - d0, 1);
        for (int i = 0; i < 4; i++)
            checkOutput("gap_data", obsParam(1, 600 + i), 32'h51 + i);
        if (writeCycles.size() >= nq + 4) begin
            for (int i = 1; i < 4; i++)
                checkOutput("gap_spacing", writeCycles[nq + i] - writeCycles[nq + i - 1], 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 clk  input  1  single clock for all logic.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 cmd_valid  input  1  load command present.
REQ-004 cmd_ready  output  1  high only in IDLE.
REQ-005 cmd_target  input  2  0=image, 1=conv, 2=dense, 3=denseb.
REQ-006 cmd_base  input  15  start address; image uses bits [9:0] as a word address.
REQ-007 cmd_len  input  16  byte count, 1..32768.
REQ-008 in_valid / in_ready / in_data  input / output / input  1 / 1 / 8  byte stream, valid/ready.
REQ-009 abort  input  1  synchronous cancel of the current load.
REQ-010 image_ram_addr_a  output  10; data_image0..3  output  8 each; we_image0..3  output  1 each.
REQ-011 conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a  output  15 each; data_conv, data_dense, data_denseb  output  8 each; we_conv, we_dense, we_denseb  output  1 each.
REQ-012 busy  output  1  high in LOAD.
REQ-013 done  output  1  one-cycle pulse when the last byte is written.
REQ-014 err  output  1  one-cycle pulse on a rejected command.

Function
REQ-015 FSM states SHALL be IDLE and LOAD only.
REQ-016 IDLE->LOAD SHALL occur on cmd_valid&&cmd_ready with a legal command; target, base and remaining count SHALL be latched.
REQ-017 Legality: cmd_len != 0; image: cmd_base[9:0]*4 + cmd_len <= 4096; others: cmd_base + cmd_len <= 32768.
REQ-018 An illegal command SHALL be consumed, pulse err the next cycle, and leave the FSM in IDLE.
REQ-019 in_ready SHALL equal (state==LOAD); a byte is accepted on in_valid&&in_ready.
REQ-020 Each accepted byte SHALL produce exactly one write strobe, registered, on the cycle after acceptance, with address and data valid in that same cycle.
REQ-021 conv/dense/denseb: byte k SHALL be written to cmd_base+k on the selected RAM only.
REQ-022 image: byte k SHALL go to bank (k mod 4) at word address cmd_base+(k div 4); one we_imageN high per write.
REQ-023 All unselected write enables SHALL be 0; when idle, all write enables SHALL be 0.
REQ-024 Acceptance of the last byte SHALL return the FSM to IDLE; done SHALL pulse together with the final write strobe.
REQ-025 Back-to-back acceptance SHALL sustain one byte per cycle; in_valid gaps SHALL produce no writes.
REQ-026 abort in LOAD SHALL force IDLE the next cycle; a byte accepted in the abort cycle SHALL NOT be written; done SHALL NOT pulse.
REQ-027 abort in IDLE SHALL be ignored; abort coincident with a command SHALL reject it silently (no err).
REQ-028 Address counters SHALL NOT wrap; REQ-017 guarantees in-range addresses.

Reset
REQ-029 On reset: state=IDLE; all we_* = 0; all addresses and data = 0; busy, done, err = 0; counters cleared.
REQ-030 Reset mid-LOAD SHALL discard the load; no write strobe SHALL appear after reset asserts.

Structure
REQ-031 Package npu_pkg SHALL hold the target enum (TGT_IMAGE, TGT_CONV, TGT_DENSE, TGT_DENSEB), IMAGE_WORDS=1024, IMAGE_BANKS=4, PARAM_DEPTH=32768, and address widths 10/15.
REQ-032 mem_loader SHALL be a single module with no sub-modules, connecting directly to the write ports of the memory wrapper.

Verification
REQ-033 conv, base=100, len=3, bytes 0x11,0x22,0x33 sent back-to-back -> we_conv for 3 consecutive cycles at addresses 100,101,102; done with the third write.
REQ-034 image, base=5, len=6, bytes 1..6 -> bank0..3 at word 5 get 1..4; bank0,1 at word 6 get 5,6.
REQ-035 dense, base=32760, len=9 -> err pulse, no writes, cmd_ready high the next cycle.
REQ-036 denseb, len=4, abort asserted with byte 3 -> bytes 1,2 written, byte 3 not written, no done, IDLE the next cycle.
REQ-037 Reset asserted mid-load of conv len=10 after 4 bytes -> all we_* low immediately, busy=0; a new command is accepted after reset.
REQ-038 conv, len=4, in_valid toggling 1,0,1,0,... -> exactly 4 writes at consecutive addresses, each one cycle after its acceptance.
